// File: rtl/gmsk_burst_serializer.sv
// Burst framer for a GMSK modulator: head tail, payload, end tail, guard, one bit per BIT_PERIOD.
// Define GMSK_DIFF_ENCODE_EN to differentially encode every emitted bit.
module gmsk_burst_serializer #(
  parameter int unsigned BIT_PERIOD   = 48,
  parameter int unsigned PAYLOAD_BITS = 142,
  parameter int unsigned GUARD_BITS   = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clk_en,
  input  logic burst_start,
  input  logic data_in,
  input  logic data_valid,
  output logic data_ready,
  output logic input_bit,
  output logic input_bit_strobe,
  output logic burst_active,
  output logic underrun
);

  typedef enum logic [2:0] {
    StIdle,
    StHeadTail,
    StPayload,
    StEndTail,
    StGuard
  } state_e;

  localparam logic [7:0] DivLast   = 8'(BIT_PERIOD - 1);
  localparam logic [7:0] PayLast   = 8'(PAYLOAD_BITS - 1);
  localparam logic [7:0] TailLast  = 8'd2;
  localparam logic [7:0] GuardLast = (GUARD_BITS == 0) ? 8'd0 : 8'(GUARD_BITS - 1);

  state_e     state_q;
  logic [7:0] div_q;
  logic [7:0] cnt_q;
  logic       tick;
  logic       raw_bit;
  logic       out_bit;

  assign tick       = clk_en && (div_q == DivLast) && (state_q != StIdle);
  assign data_ready = tick && (state_q == StPayload);

  // Missing payload data is sent as a zero.
  always_comb begin
    raw_bit = 1'b0;
    case (state_q)
      StPayload: raw_bit = data_valid & data_in;
      StGuard:   raw_bit = 1'b1;
      default:   raw_bit = 1'b0;
    endcase
  end

`ifdef GMSK_DIFF_ENCODE_EN
  logic diff_prev_q;
  assign out_bit = raw_bit ^ diff_prev_q;
`else
  assign out_bit = raw_bit;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      div_q            <= 8'd0;
      cnt_q            <= 8'd0;
      input_bit        <= 1'b0;
      input_bit_strobe <= 1'b0;
      burst_active     <= 1'b0;
      underrun         <= 1'b0;
`ifdef GMSK_DIFF_ENCODE_EN
      diff_prev_q      <= 1'b1;
`endif
    end else begin
      input_bit_strobe <= 1'b0;
      if (state_q == StIdle) begin
        if (burst_start) begin
          state_q      <= StHeadTail;
          div_q        <= 8'd0;
          cnt_q        <= 8'd0;
          underrun     <= 1'b0;
          burst_active <= 1'b1;
`ifdef GMSK_DIFF_ENCODE_EN
          diff_prev_q  <= 1'b1;
`endif
        end
      end else if (tick) begin
        div_q            <= 8'd0;
        cnt_q            <= cnt_q + 8'd1;
        input_bit        <= out_bit;
        input_bit_strobe <= 1'b1;
`ifdef GMSK_DIFF_ENCODE_EN
        diff_prev_q      <= raw_bit;
`endif
        if ((state_q == StPayload) && !data_valid) begin
          underrun <= 1'b1;
        end
        case (state_q)
          StHeadTail: begin
            if (cnt_q == TailLast) begin
              state_q <= StPayload;
              cnt_q   <= 8'd0;
            end
          end
          StPayload: begin
            if (cnt_q == PayLast) begin
              state_q <= StEndTail;
              cnt_q   <= 8'd0;
            end
          end
          StEndTail: begin
            if (cnt_q == TailLast) begin
              cnt_q <= 8'd0;
              if (GUARD_BITS == 0) begin
                state_q      <= StIdle;
                burst_active <= 1'b0;
              end else begin
                state_q <= StGuard;
              end
            end
          end
          StGuard: begin
            if (cnt_q == GuardLast) begin
              state_q      <= StIdle;
              cnt_q        <= 8'd0;
              burst_active <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end else if (clk_en) begin
        div_q <= div_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_gmsk_burst_serializer.sv
// Randomized scoreboard bench for gmsk_burst_serializer (small burst geometry).
module tb_gmsk_burst_serializer;

  localparam int unsigned BP    = 4;
  localparam int unsigned PB    = 4;
  localparam int unsigned GB    = 2;
  localparam int unsigned NBITS = 6 + PB + GB;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clk_en = 1'b0;
  logic burst_start = 1'b0;
  logic data_in = 1'b0;
  logic data_valid = 1'b0;
  logic data_ready, input_bit, input_bit_strobe, burst_active, underrun;

  gmsk_burst_serializer #(
    .BIT_PERIOD  (BP),
    .PAYLOAD_BITS(PB),
    .GUARD_BITS  (GB)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .clk_en          (clk_en),
    .burst_start     (burst_start),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .input_bit       (input_bit),
    .input_bit_strobe(input_bit_strobe),
    .burst_active    (burst_active),
    .underrun        (underrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic b;
    bit   first;
    bit   last;
  } exp_t;

  exp_t   exp_q[$];
  int     total = 0;
  int     bad = 0;
  int     strobe_cnt = 0;
  int     exp_gap = 0;
  longint cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b, required %0b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: the whole burst as a list of bits, built directly from the frame layout.
  function automatic void push_expected(input logic [PB-1:0] pay, input logic [PB-1:0] vld);
    logic raw;
    logic prev;
    exp_t e;
    prev = 1'b1;
    for (int i = 0; i < int'(NBITS); i++) begin
      if (i < 3)                 raw = 1'b0;
      else if (i < 3 + int'(PB)) raw = vld[i-3] & pay[i-3];
      else if (i < 6 + int'(PB)) raw = 1'b0;
      else                       raw = 1'b1;
`ifdef GMSK_DIFF_ENCODE_EN
      e.b  = raw ^ prev;
      prev = raw;
`else
      e.b = raw;
`endif
      e.first = (i == 0);
      e.last  = (i == int'(NBITS) - 1);
      exp_q.push_back(e);
    end
  endfunction

  initial begin : monitor
    exp_t   e;
    longint last_cyc;
    last_cyc = 0;
    forever begin
      @(negedge clock);
      if (input_bit_strobe === 1'b1) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got strobe with bit %0b, required no strobe (cycle %0d)",
                   input_bit, cyc);
        end else begin
          e = exp_q.pop_front();
          check("input_bit", input_bit, e.b);
          if (!e.first && exp_gap != 0) check_int("strobe_gap", int'(cyc - last_cyc), exp_gap);
          if (e.last) check("burst_active_after_last", burst_active, 1'b0);
        end
        last_cyc = cyc;
      end
    end
  end

  // Modes: 0 fixed payload, 1 underrun, 2 clk_en toggling, 3 burst_start in payload,
  // 4 reset in payload, 5 random clk_en and validity.
  task automatic run_burst(input int mode);
    logic [PB-1:0] pay;
    logic [PB-1:0] vld;
    logic [3:0]    fixed;
    int            k;
    int            guard;
    int            s0;
    logic          en;
    bit            pulsed;
    logic          exp_under;
    pay   = PB'($urandom);
    vld   = '1;
    fixed = 4'b1101;
    if (mode == 0) pay = PB'(fixed);
    if (mode == 1) begin
      vld    = PB'($urandom);
      vld[1] = 1'b0;
    end
    if (mode == 5) vld = PB'($urandom | $urandom);
    exp_under = ~&vld;
    exp_gap   = (mode == 2) ? int'(2 * BP) : (mode == 5) ? 0 : int'(BP);
    push_expected(pay, vld);
    s0 = strobe_cnt;

    @(negedge clock); #1;
    burst_start = 1'b1;
    clk_en      = 1'b1;
    @(negedge clock); #1;
    burst_start = 1'b0;
    check("underrun_cleared_at_start", underrun, 1'b0);
    check("burst_active_at_start", burst_active, 1'b1);

    k = 0; en = 1'b1; pulsed = 1'b0; guard = 0;
    while (guard < 1000) begin
      if (mode == 4 && k == 2) begin
        reset = 1'b1;
        clk_en = 1'b1;
        exp_q.delete();
        @(negedge clock); #1;
        check("rst_input_bit", input_bit, 1'b0);
        check("rst_strobe", input_bit_strobe, 1'b0);
        check("rst_burst_active", burst_active, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_data_ready", data_ready, 1'b0);
        reset = 1'b0;
        s0 = strobe_cnt;
        repeat (40) @(negedge clock);
        #1;
        check_int("strobes_after_reset", strobe_cnt - s0, 0);
        return;
      end
      if (mode == 2) en = ~en;
      else if (mode == 5) en = 1'($urandom_range(0, 1));
      else en = 1'b1;
      clk_en = en;
      if (mode == 3 && k == 2 && !pulsed) begin
        burst_start = 1'b1;
        pulsed = 1'b1;
      end else begin
        burst_start = 1'b0;
      end
      if (k < int'(PB)) begin
        data_in    = pay[k];
        data_valid = vld[k];
      end else begin
        data_in    = 1'($urandom);
        data_valid = 1'($urandom);
      end
      #1;
      if (data_ready === 1'b1) k++;
      @(negedge clock); #1;
      guard++;
      if (exp_q.size() == 0 && burst_active === 1'b0) break;
    end
    burst_start = 1'b0;
    data_valid  = 1'b0;
    if (guard >= 1000) begin
      total++;
      bad++;
      $display("FAIL burst_timeout: got %0d pending bits, required 0", exp_q.size());
      exp_q.delete();
    end
    check_int("strobes_per_burst", strobe_cnt - s0, int'(NBITS));
    check_int("payload_consumed", k, int'(PB));
    check("underrun_sticky", underrun, exp_under);
  endtask

  initial begin : stimulus
    int modes[12] = '{0, 1, 0, 2, 3, 4, 0, 5, 1, 5, 2, 5};
    repeat (3) @(negedge clock);
    #1;
    check("reset_input_bit", input_bit, 1'b0);
    check("reset_strobe", input_bit_strobe, 1'b0);
    check("reset_burst_active", burst_active, 1'b0);
    check("reset_underrun", underrun, 1'b0);
    check("reset_data_ready", data_ready, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      run_burst(modes[i]);
      repeat (3) @(negedge clock);
    end
    check_int("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gmsk_burst_serializer.md
GMSK_BURST_SERIALIZER -- requirements
Module: gmsk_burst_serializer

Interface
REQ-001 SHALL have parameter BIT_PERIOD, default 48, number of clk_en-qualified clocks per output bit; legal range 2..255.
REQ-002 SHALL have parameter PAYLOAD_BITS, default 142, number of payload bits per burst; legal range 1..255.
REQ-003 SHALL have parameter GUARD_BITS, default 8, number of guard bits appended after the trailing tail; legal range 0..15.
REQ-004 SHALL use a single clock and a synchronous, active-high reset.
REQ-005 clock  input  1  system clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 clk_en  input  1  clock enable; the bit divider advances only when high.
REQ-008 burst_start  input  1  single-cycle request to begin a burst.
REQ-009 data_in  input  1  payload bit offered by upstream.
REQ-010 data_valid  input  1  data_in is valid.
REQ-011 data_ready  output  1  combinational; high only in the cycle a payload bit is consumed.
REQ-012 input_bit  output  1  registered bit to the GMSK modulator.
REQ-013 input_bit_strobe  output  1  registered single-cycle pulse marking a new input_bit.
REQ-014 burst_active  output  1  registered; high while any burst state is active.
REQ-015 underrun  output  1  registered sticky flag; a payload bit was due while data_valid was low.

Function
REQ-016 SHALL implement the states IDLE, HEAD_TAIL, PAYLOAD, END_TAIL and GUARD.
REQ-017 In IDLE, burst_start=1 SHALL, on the next edge, enter HEAD_TAIL, clear the divider and bit counter, clear underrun, and set burst_active.
REQ-018 burst_start SHALL be ignored in every state except IDLE, with no effect on the current burst.
REQ-019 The divider SHALL increment on clk_en; "tick" = clk_en AND divider==BIT_PERIOD-1, after which the divider wraps to 0.
REQ-020 On each tick in a non-IDLE state, input_bit SHALL be loaded and input_bit_strobe asserted for exactly the following clock; otherwise strobe=0.
REQ-021 HEAD_TAIL SHALL emit 3 bits of value 0, then go to PAYLOAD.
REQ-022 PAYLOAD SHALL emit PAYLOAD_BITS bits, then go to END_TAIL.
REQ-023 In PAYLOAD, data_ready = tick; when data_valid=1, input_bit source = data_in.
REQ-024 If data_valid=0 at a PAYLOAD tick, the emitted bit SHALL be 0, underrun SHALL set, and the bit SHALL still count toward PAYLOAD_BITS.
REQ-025 END_TAIL SHALL emit 3 bits of value 0, then go to GUARD, or straight to IDLE if GUARD_BITS=0.
REQ-026 GUARD SHALL emit GUARD_BITS bits of value 1, then go to IDLE.
REQ-027 burst_active SHALL drop on the edge that returns the block to IDLE; the final strobe of the burst still occurs.
REQ-028 Total strobes per burst SHALL be exactly 6+PAYLOAD_BITS+GUARD_BITS.
REQ-029 With clk_en held low, all counters and state SHALL freeze and strobes SHALL cease.

Reset
REQ-030 Reset SHALL force state=IDLE, divider=0, bit counter=0, input_bit=0, input_bit_strobe=0, burst_active=0, underrun=0, and the differential register=1.
REQ-031 Reset asserted mid-burst SHALL abort the burst on that edge with no further strobes; reset has priority over burst_start.

Configuration
REQ-032 With GMSK_DIFF_ENCODE_EN defined, every emitted bit SHALL be b XOR prev, where prev is the previous raw bit; prev is set to 1 at burst start (GSM 05.04 differential encoding).
REQ-033 With GMSK_DIFF_ENCODE_EN undefined, input_bit SHALL equal the raw bit and no differential register shall exist.

Verification (BIT_PERIOD=4, PAYLOAD_BITS=4, GUARD_BITS=2, clk_en=1 unless stated)
REQ-034 Reset, then burst_start pulse, payload 1,0,1,1 always valid, macro undefined -> 12 strobes spaced 4 clocks apart with bits 0,0,0,1,0,1,1,0,0,0,1,1; burst_active low after the 12th strobe; underrun=0.
REQ-035 Same stimulus with GMSK_DIFF_ENCODE_EN defined -> bits 1,0,0,1,1,1,0,1,0,0,1,0.
REQ-036 data_valid low for the second payload bit -> that bit is 0, underrun=1 until the next burst_start, and the burst still totals 12 strobes.
REQ-037 clk_en toggling 1,0 every clock -> strobes spaced 8 clocks apart, identical bit sequence to REQ-034.
REQ-038 burst_start pulsed during PAYLOAD -> ignored, exactly 12 strobes; reset during PAYLOAD -> all outputs 0 on the next clock and no strobes until a new burst_start.
